mfm_sector_data: RTL

Downstream companion to the sector header decoder in the MFM read chain. After a valid ID header, it waits for the next sync, checks the data address mark (0xFB normal, 0xF8 deleted) and streams the sector payload out as addressed byte writes for a sector buffer. It also runs CRC-16-CCITT over the data field and reports completion with a CRC status. Inputs are the sync pulse and byte stream from the bit FIFO, plus the header decoder's valid strobe and fields.

---
 rtl/mfm_sector_data.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mfm_sector_data.sv
// mfm_sector_data
//    Data-field stage of the MFM read chain. After the header decoder reports
//    a good ID header, this block waits for the next A1 A1 A1 sync and checks
//    the data address mark (0xFB normal, 0xF8 deleted). It then streams the
//    payload as addressed byte writes and runs CRC-16-CCITT over the mark,
//    the payload and the trailing CRC bytes. Completion is reported with a
//    CRC status.
//
// Ports
//    i_Clk          system clock, rising edge
//    i_Reset_n      synchronous active-low reset
//    i_Sync         one-cycle pulse: sync triple recognised
//    i_Data         byte from the bit FIFO, qualified by i_Valid
//    i_Valid        one-cycle strobe per decoded byte
//    i_HeaderValid  one-cycle strobe: ID header passed its CRC
//    i_Sector       sector number from the header
//    i_SectorSize   size code N from the header (128 << N bytes)
//    o_Addr         byte offset within the sector
//    o_Byte         payload byte
//    o_Write        one-cycle write strobe for o_Addr/o_Byte
//    o_Done         one-cycle pulse: field complete, CRC checked
//    o_CRCError     last completed field failed its CRC
//    o_Deleted      last completed field carried mark 0xF8
//    o_Sector       sector number of the last completed field
//    o_State        current state encoding (debug)
module mfm_sector_data #(
   parameter int MAX_SIZE_CODE = 2,
   parameter int GAP_MAX       = 64
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic                     i_Sync,
   input  logic [7:0]               i_Data,
   input  logic                     i_Valid,
   input  logic                     i_HeaderValid,
   input  logic [7:0]               i_Sector,
   input  logic [7:0]               i_SectorSize,
   output logic [7+MAX_SIZE_CODE-1:0] o_Addr,
   output logic [7:0]               o_Byte,
   output logic                     o_Write,
   output logic                     o_Done,
   output logic                     o_CRCError,
   output logic                     o_Deleted,
   output logic [7:0]               o_Sector,
   output logic [2:0]               o_State
);

   localparam int AW = 7 + MAX_SIZE_CODE;
   localparam int GW = $clog2(GAP_MAX) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_SYNC = 3'd1;
   localparam logic [2:0] S_MARK      = 3'd2;
   localparam logic [2:0] S_DATA      = 3'd3;
   localparam logic [2:0] S_CRC       = 3'd4;

   // CCITT register value after A1 A1 A1 starting from 0xFFFF; the sync
   // bytes are consumed upstream, so the CRC starts from here.
   localparam logic [15:0] CRC_PRESET = 16'hCDB4;

   // CRC-16-CCITT, polynomial 0x1021, one byte MSB first.
   function automatic logic [15:0] f_CrcByte(input logic [15:0] crc,
                                             input logic [7:0]  d);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Offset of the last payload byte for size code n.
   function automatic logic [AW-1:0] f_LastAddr(input logic [7:0] n);
      logic [31:0] last;
      last = (32'd128 << n) - 32'd1;
      return last[AW-1:0];
   endfunction

   logic [2:0]    r_State;
   logic [7:0]    r_N;
   logic [7:0]    r_SectorHdr;
   logic [GW-1:0] r_Gap;
   logic [AW-1:0] r_Cnt;
   logic [15:0]   r_Crc;
   logic          r_Del;
   logic          r_CrcSecond;
   logic [AW-1:0] r_Addr;
   logic [7:0]    r_Byte;
   logic          r_Write;
   logic          r_Done;
   logic          r_CrcErr;
   logic          r_Deleted;
   logic [7:0]    r_SectorOut;

   logic [15:0]   w_CrcNext;
   logic          w_SizeOk;
   logic          w_GoodMark;
   logic [AW-1:0] w_LastAddr;

   assign w_CrcNext  = f_CrcByte(r_Crc, i_Data);
   assign w_SizeOk   = (i_SectorSize <= 8'(MAX_SIZE_CODE));
   assign w_GoodMark = (i_Data == 8'hFB) || (i_Data == 8'hF8);
   assign w_LastAddr = f_LastAddr(r_N);

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         r_State     <= S_IDLE;
         r_N         <= 8'd0;
         r_SectorHdr <= 8'd0;
         r_Gap       <= '0;
         r_Cnt       <= '0;
         r_Crc       <= 16'd0;
         r_Del       <= 1'b0;
         r_CrcSecond <= 1'b0;
         r_Addr      <= '0;
         r_Byte      <= 8'd0;
         r_Write     <= 1'b0;
         r_Done      <= 1'b0;
         r_CrcErr    <= 1'b0;
         r_Deleted   <= 1'b0;
         r_SectorOut <= 8'd0;
      end else begin
         r_Write <= 1'b0;
         r_Done  <= 1'b0;
         case (r_State)
            S_IDLE: begin
               if (i_HeaderValid && w_SizeOk) begin
                  r_SectorHdr <= i_Sector;
                  r_N         <= i_SectorSize;
                  r_Gap       <= '0;
                  r_State     <= S_WAIT_SYNC;
               end
            end
            S_WAIT_SYNC: begin
               // Sync takes priority; a byte arriving with it is dropped
               // and does not count towards the gap limit.
               if (i_Sync) begin
                  r_Crc   <= CRC_PRESET;
                  r_State <= S_MARK;
               end else if (i_HeaderValid) begin
                  // A newer header restarts the wait; an oversize one
                  // cannot be followed, so give up on the sector.
                  if (w_SizeOk) begin
                     r_SectorHdr <= i_Sector;
                     r_N         <= i_SectorSize;
                     r_Gap       <= '0;
                  end else begin
                     r_State <= S_IDLE;
                  end
               end else if (i_Valid) begin
                  if (r_Gap == GW'(GAP_MAX - 1)) r_State <= S_IDLE;
                  else                           r_Gap   <= r_Gap + 1'b1;
               end
            end
            S_MARK: begin
               if (i_Sync) begin
                  r_State <= S_IDLE;
               end else if (i_Valid) begin
                  if (w_GoodMark) begin
                     r_Crc   <= w_CrcNext;
                     r_Del   <= (i_Data == 8'hF8);
                     r_Cnt   <= '0;
                     r_State <= S_DATA;
                  end else begin
                     r_State <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (i_Sync) begin
                  r_State <= S_IDLE;
               end else if (i_Valid) begin
                  r_Crc   <= w_CrcNext;
                  r_Write <= 1'b1;
                  r_Addr  <= r_Cnt;
                  r_Byte  <= i_Data;
                  if (r_Cnt == w_LastAddr) begin
                     r_CrcSecond <= 1'b0;
                     r_State     <= S_CRC;
                  end else begin
                     r_Cnt <= r_Cnt + 1'b1;
                  end
               end
            end
            S_CRC: begin
               if (i_Sync) begin
                  r_State <= S_IDLE;
               end else if (i_Valid) begin
                  r_Crc <= w_CrcNext;
                  if (r_CrcSecond) begin
                     // Feeding the stored CRC through leaves a zero residue
                     // when the field is intact.
                     r_Done      <= 1'b1;
                     r_CrcErr    <= (w_CrcNext != 16'd0);
                     r_Deleted   <= r_Del;
                     r_SectorOut <= r_SectorHdr;
                     r_State     <= S_IDLE;
                  end else begin
                     r_CrcSecond <= 1'b1;
                  end
               end
            end
            default: r_State <= S_IDLE;
         endcase
      end
   end

   assign o_Addr     = r_Addr;
   assign o_Byte     = r_Byte;
   assign o_Write    = r_Write;
   assign o_Done     = r_Done;
   assign o_CRCError = r_CrcErr;
   assign o_Deleted  = r_Deleted;
   assign o_Sector   = r_SectorOut;
   assign o_State    = r_State;

endmodule
